// File: rtl/stf_gen_pkg.sv
// stf_gen_pkg
//   Shared definitions for the short-training-field streamer:
//   FSM state encoding, STF period length and the per-phase I/Q sign pattern.
package stf_gen_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  // Samples per STF period.
  localparam int PERIOD = 16;

  // Sign pattern indexed by phase p = k mod 4; a set bit means +A, clear means -A.
  //   I: + for p in {0,1}
  //   Q: + for p in {0,3}
  localparam logic [3:0] I_POS = 4'b0011;
  localparam logic [3:0] Q_POS = 4'b1001;

endpackage

// File: rtl/stf_sample_lut.sv
// stf_sample_lut
//   Combinational map from (phase, halve) to one packed {I,Q} STF sample.
//   Ports:
//     phase  in  2            k mod 4 of the sample being produced
//     halve  in  1            use AMP>>1 instead of AMP (edge windowing)
//     iq     out 2*IQ_WIDTH   {I,Q}, two's complement, I in the upper half
module stf_sample_lut
  import stf_gen_pkg::*;
#(
  parameter int IQ_WIDTH = 16,
  parameter int AMP      = 16'h02F2
) (
  input  logic [1:0]            phase,
  input  logic                  halve,
  output logic [2*IQ_WIDTH-1:0] iq
);

  localparam logic [IQ_WIDTH-1:0] AMP_FULL = IQ_WIDTH'(AMP);
  localparam logic [IQ_WIDTH-1:0] AMP_HALF = AMP_FULL >> 1;

  logic [IQ_WIDTH-1:0] amp_sel;
  logic [IQ_WIDTH-1:0] amp_neg;

  // Halve first, then negate: -(AMP>>1), not (-AMP)>>>1.
  assign amp_sel = halve ? AMP_HALF : AMP_FULL;
  assign amp_neg = -amp_sel;

  assign iq = {(I_POS[phase] ? amp_sel : amp_neg),
               (Q_POS[phase] ? amp_sel : amp_neg)};

endmodule

// File: rtl/stf_gen.sv
// stf_gen
//   Streams num_rep repetitions of the 16-sample STF over a valid/ready port.
//   Ports:
//     clock    in   1            clock
//     reset    in   1            asynchronous active-high reset
//     start    in   1            begin a burst (honoured only in IDLE)
//     num_rep  in   4            number of periods, captured with start
//     abort    in   1            cancel the burst in progress, no done pulse
//     m_valid  out  1            sample valid
//     m_ready  in   1            downstream accept
//     m_data   out  2*IQ_WIDTH   {I,Q} sample
//     m_last   out  1            final sample of the burst
//     busy     out  1            high in RUN and FIN
//     done     out  1            one-cycle completion pulse (FIN)
module stf_gen
  import stf_gen_pkg::*;
#(
  parameter int IQ_WIDTH = 16,
  parameter int AMP      = 16'h02F2,
  parameter int WINDOW   = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [3:0]            num_rep,
  input  logic                  abort,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [2*IQ_WIDTH-1:0] m_data,
  output logic                  m_last,
  output logic                  busy,
  output logic                  done
);

  state_t     state_reg, state_next;
  logic [7:0] k_reg, k_next;
  logic [7:0] total_reg, total_next;
  logic       halve;
  logic       last_next;
  logic [2*IQ_WIDTH-1:0] iq;

  always_comb begin
    state_next = state_reg;
    k_next     = k_reg;
    total_next = total_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          total_next = 8'(PERIOD) * {4'b0000, num_rep};
          k_next     = '0;
          state_next = (num_rep != 4'd0) ? RUN : FIN;
        end
      end
      RUN: begin
        if (m_valid && m_ready) begin
          if (k_reg == total_reg - 8'd1) state_next = FIN;
          else                           k_next     = k_reg + 8'd1;
        end
      end
      FIN:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
    // Abort wins over everything, including a simultaneous final handshake.
    if (abort) begin
      state_next = IDLE;
      k_next     = '0;
    end
  end

  // The output registers are loaded from the *next* index, so the sample for
  // k+1 is on the bus the cycle after the handshake on k.
  assign halve     = (WINDOW != 0) && ((k_next == 8'd0) || (k_next == total_next - 8'd1));
  assign last_next = (state_next == RUN) && (k_next == total_next - 8'd1);

  stf_sample_lut #(
    .IQ_WIDTH (IQ_WIDTH),
    .AMP      (AMP)
  ) u_lut (
    .phase (k_next[1:0]),
    .halve (halve),
    .iq    (iq)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      k_reg     <= '0;
      total_reg <= '0;
      m_valid   <= 1'b0;
      m_data    <= '0;
      m_last    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state_reg <= state_next;
      k_reg     <= k_next;
      total_reg <= total_next;
      m_valid   <= (state_next == RUN);
      m_data    <= (state_next == RUN) ? iq : '0;
      m_last    <= last_next;
      busy      <= (state_next != IDLE);
      done      <= (state_next == FIN);
    end
  end

endmodule

// File: tb/tb_stf_gen.sv
module tb_stf_gen;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  num_rep = 4'd0;
  logic        abort = 1'b0;
  logic        m_ready = 1'b0;

  // a: defaults (16-bit, windowed); b: 16-bit unwindowed; c: 12-bit unwindowed
  logic        a_valid, a_last, a_busy, a_done;
  logic [31:0] a_data;
  logic        b_valid, b_last, b_busy, b_done;
  logic [31:0] b_data;
  logic        c_valid, c_last, c_busy, c_done;
  logic [23:0] c_data;

  int tests = 0;
  int fails = 0;

  always #5 clock = ~clock;

  stf_gen dut_a (
    .clock(clock), .reset(reset), .start(start), .num_rep(num_rep), .abort(abort),
    .m_valid(a_valid), .m_ready(m_ready), .m_data(a_data), .m_last(a_last),
    .busy(a_busy), .done(a_done)
  );

  stf_gen #(.IQ_WIDTH(16), .AMP(16'h02F2), .WINDOW(0)) dut_b (
    .clock(clock), .reset(reset), .start(start), .num_rep(num_rep), .abort(abort),
    .m_valid(b_valid), .m_ready(m_ready), .m_data(b_data), .m_last(b_last),
    .busy(b_busy), .done(b_done)
  );

  stf_gen #(.IQ_WIDTH(12), .AMP(12'h2F2), .WINDOW(0)) dut_c (
    .clock(clock), .reset(reset), .start(start), .num_rep(num_rep), .abort(abort),
    .m_valid(c_valid), .m_ready(m_ready), .m_data(c_data), .m_last(c_last),
    .busy(c_busy), .done(c_done)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference sample from the STF rules: phase k mod 4 picks the signs,
  // window halves the edge amplitude before the sign is applied.
  function automatic logic [31:0] exp_iq(input int w, input int amp, input bit win,
                                         input int k, input int total);
    int a, mask, p, iv, qv;
    a    = (win && (k == 0 || k == total - 1)) ? amp / 2 : amp;
    mask = (1 << w) - 1;
    p    = k % 4;
    iv   = (p == 0 || p == 1) ? a : -a;
    qv   = (p == 0 || p == 3) ? a : -a;
    return 32'(((iv & mask) << w) | (qv & mask));
  endfunction

  // Model state: index of the next sample the burst must present.
  int          hs_cnt = 0;
  int          cur_total = 0;
  bit          stalled [3];
  logic [31:0] held    [3];

  task automatic mcheck(input int id, input logic valid, input logic [31:0] data,
                        input logic last, input int w, input bit win);
    if (stalled[id]) begin
      chk($sformatf("stall_valid%0d", id), {31'b0, valid}, 32'd1);
      chk($sformatf("stall_data%0d", id), data, held[id]);
    end
    if (valid) begin
      chk($sformatf("seq_data%0d_k%0d", id, hs_cnt), data,
          exp_iq(w, 32'h2F2, win, hs_cnt, cur_total));
      chk($sformatf("seq_last%0d_k%0d", id, hs_cnt), {31'b0, last},
          {31'b0, (hs_cnt == cur_total - 1)});
    end
    stalled[id] = valid && !m_ready && !abort;
    held[id]    = data;
  endtask

  always @(negedge clock) begin
    if (reset) begin
      hs_cnt = 0;
      for (int i = 0; i < 3; i++) stalled[i] = 1'b0;
    end else begin
      mcheck(0, a_valid, a_data, a_last, 16, 1'b1);
      mcheck(1, b_valid, b_data, b_last, 16, 1'b0);
      mcheck(2, c_valid, {8'b0, c_data}, c_last, 12, 1'b0);
      if (a_valid && m_ready) hs_cnt++;
      if (start && !a_busy) begin
        hs_cnt    = 0;
        cur_total = 16 * int'(num_rep);
      end
    end
  end

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic pulse_start(input logic [3:0] n);
    start = 1'b1;
    num_rep = n;
    tick();
    start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int hs;
    // ---- reset values
    tick(); tick();
    chk("rst_valid", {31'b0, a_valid}, 32'd0);
    chk("rst_data",  a_data, 32'd0);
    chk("rst_last",  {31'b0, a_last}, 32'd0);
    chk("rst_busy",  {31'b0, a_busy}, 32'd0);
    chk("rst_done",  {31'b0, a_done}, 32'd0);
    reset = 1'b0;
    m_ready = 1'b1;
    tick();

    // ---- single windowed burst, literal pins
    pulse_start(4'd1);
    chk("s0", a_data, 32'h0179_0179);
    chk("s0_busy", {31'b0, a_busy}, 32'd1);
    tick(); chk("s1", a_data, 32'h02F2_FD0E);
    tick(); chk("s2", a_data, 32'hFD0E_FD0E);
    chk("s2_w12", {8'b0, c_data}, 32'h00D0_ED0E);
    tick(); chk("s3", a_data, 32'hFD0E_02F2);
    for (int i = 0; i < 12; i++) tick();
    chk("s15", a_data, 32'hFE87_0179);
    chk("s15_last", {31'b0, a_last}, 32'd1);
    tick();
    chk("end_valid", {31'b0, a_valid}, 32'd0);
    chk("end_done", {31'b0, a_done}, 32'd1);
    chk("end_busy", {31'b0, a_busy}, 32'd1);
    tick();
    chk("end_done_clr", {31'b0, a_done}, 32'd0);
    chk("end_busy_clr", {31'b0, a_busy}, 32'd0);

    // ---- full 802.11 burst, unwindowed
    pulse_start(4'd10);
    hs = 0;
    for (int c = 0; c < 200 && b_valid; c++) begin
      if (hs % 4 == 0) chk("full_4n", b_data, 32'h02F2_02F2);
      chk("full_last", {31'b0, b_last}, {31'b0, (hs == 159)});
      hs++;
      tick();
    end
    chk("full_count", 32'(hs), 32'd160);
    chk("full_done", {31'b0, b_done}, 32'd1);
    tick();

    // ---- backpressure
    pulse_start(4'd2);
    hs = 0;
    for (int c = 0; c < 400 && a_valid; c++) begin
      m_ready = 1'($urandom_range(0, 1));
      if (m_ready) hs++;
      tick();
    end
    m_ready = 1'b1;
    chk("bp_count", 32'(hs), 32'd32);
    chk("bp_done", {31'b0, a_done}, 32'd1);
    tick();

    // ---- abort on the 7th sample with a simultaneous handshake
    pulse_start(4'd1);
    for (int i = 0; i < 6; i++) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_valid", {31'b0, a_valid}, 32'd0);
    chk("abort_busy", {31'b0, a_busy}, 32'd0);
    chk("abort_done", {31'b0, a_done}, 32'd0);
    tick();
    chk("abort_done2", {31'b0, a_done}, 32'd0);
    pulse_start(4'd1);
    chk("restart_s0", a_data, 32'h0179_0179);
    // abort on the final handshake: abort wins, no done
    for (int c = 0; c < 20 && !a_last; c++) tick();
    chk("abort_at_last", {31'b0, a_last}, 32'd1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abortlast_done", {31'b0, a_done}, 32'd0);
    chk("abortlast_valid", {31'b0, a_valid}, 32'd0);
    tick();
    chk("abortlast_done2", {31'b0, a_done}, 32'd0);

    // ---- start ignored during RUN and FIN
    pulse_start(4'd1);
    hs = 0;
    for (int c = 0; c < 40 && a_valid; c++) begin
      start = (c == 3);
      num_rep = (c == 3) ? 4'd5 : 4'd1;
      hs++;
      tick();
    end
    start = 1'b0;
    chk("ign_run_count", 32'(hs), 32'd16);
    chk("ign_fin_done", {31'b0, a_done}, 32'd1);
    pulse_start(4'd1);
    chk("ign_fin_busy", {31'b0, a_busy}, 32'd0);
    chk("ign_fin_valid", {31'b0, a_valid}, 32'd0);
    tick();
    chk("ign_fin_valid2", {31'b0, a_valid}, 32'd0);

    // ---- num_rep = 0
    pulse_start(4'd0);
    chk("zero_valid", {31'b0, a_valid}, 32'd0);
    chk("zero_done", {31'b0, a_done}, 32'd1);
    tick();
    chk("zero_done_clr", {31'b0, a_done}, 32'd0);
    chk("zero_busy_clr", {31'b0, a_busy}, 32'd0);

    // ---- asynchronous reset mid-burst
    pulse_start(4'd3);
    tick(); tick();
    reset = 1'b1;
    #1;
    chk("arst_valid", {31'b0, a_valid}, 32'd0);
    chk("arst_data", a_data, 32'd0);
    chk("arst_busy", {31'b0, a_busy}, 32'd0);
    tick();
    reset = 1'b0;
    tick();
    pulse_start(4'd1);
    chk("post_rst_s0", a_data, 32'h0179_0179);
    for (int c = 0; c < 20 && a_valid; c++) tick();
    tick(); tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
